// File: rtl/inst_fetch_queue_if.sv
// Bus between the fetch stage / instruction SRAM (master) and the fetch queue (slave).
// The fetch side drives requests and the SRAM response. Decode drives deq and reads the head entries.
interface inst_fetch_queue_if #(
  parameter int AW = 3
);
  // Handshake rules:
  // - A request is accepted whenever req_valid is high. There is no ready signal.
  // - Fetch must honour stall_req, which asserts early enough to absorb the requests already in flight.
  // - inst_sram_rdata is valid in the cycle after its request.
  // - deq may only claim entries whose outN_valid is high. Excess deq is clipped to the occupancy.
  logic          req_valid;
  logic [31:0]   req_pc;
  logic [31:0]   req_tgt;
  logic          req_discard;
  logic [63:0]   inst_sram_rdata;
  logic [1:0]    deq;

  logic          out0_valid;
  logic [31:0]   out0_pc;
  logic [31:0]   out0_inst;
  logic          out1_valid;
  logic [31:0]   out1_pc;
  logic [31:0]   out1_inst;
  logic [AW:0]   count_o;
  logic          stall_req;
  logic          overflow_err;

  modport master (
    output req_valid, req_pc, req_tgt, req_discard, inst_sram_rdata, deq,
    input  out0_valid, out0_pc, out0_inst, out1_valid, out1_pc, out1_inst,
    input  count_o, stall_req, overflow_err
  );

  modport slave (
    input  req_valid, req_pc, req_tgt, req_discard, inst_sram_rdata, deq,
    output out0_valid, out0_pc, out0_inst, out1_valid, out1_pc, out1_inst,
    output count_o, stall_req, overflow_err
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue. Pairs each fetch request with its SRAM response one cycle later,
// keeps the useful words as {pc, inst} entries in a circular FIFO, and lets decode pop up to two per cycle.
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  inst_fetch_queue_if.slave bus
);

  localparam int CW = AW + 2;

  // Response stage: the request whose SRAM data is on inst_sram_rdata this cycle
  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_tgt2;
  logic        r_discard;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic          ovf_q;
  logic [63:0]   mem [DEPTH];

  logic [1:0]    deq_eff;
  logic [1:0]    n_push;
  logic [1:0]    n_pop;
  logic [CW-1:0] room;
  logic          overflow;
  logic          push_ok;
  logic [AW-1:0] wr_idx0;
  logic [AW-1:0] wr_idx1;
  logic [AW-1:0] rd_idx0;
  logic [AW-1:0] rd_idx1;
  logic [63:0]   word_lo;
  logic [63:0]   word_hi;
  logic          unused_tgt_bits;

  assign unused_tgt_bits = ^{bus.req_tgt[31:3], bus.req_tgt[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_pc      <= 32'd0;
      r_tgt2    <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      r_valid   <= bus.req_valid & ~flush;
      r_pc      <= bus.req_pc;
      r_tgt2    <= bus.req_tgt[2];
      r_discard <= bus.req_discard;
    end
  end

  // Pointers carry one extra wrap bit, so their difference is the occupancy 0..DEPTH.
  assign count   = wr_ptr - rd_ptr;
  assign wr_idx0 = wr_ptr[AW-1:0];
  assign wr_idx1 = wr_idx0 + AW'(1);
  assign rd_idx0 = rd_ptr[AW-1:0];
  assign rd_idx1 = rd_idx0 + AW'(1);
  assign word_lo = {r_pc, bus.inst_sram_rdata[31:0]};
  assign word_hi = {r_pc + 32'd4, bus.inst_sram_rdata[63:32]};

  always_comb begin
    deq_eff  = (bus.deq == 2'd3) ? 2'd2 : bus.deq;
    n_pop    = (CW'(deq_eff) > CW'(count)) ? count[1:0] : deq_eff;
    n_push   = 2'd0;
    if (r_valid && !r_discard) begin
      n_push = r_tgt2 ? 2'd1 : 2'd2;
    end
    // Entries popped this cycle free space for this cycle's push.
    room     = CW'(DEPTH) - CW'(count) + CW'(n_pop);
    overflow = CW'(n_push) > room;
    push_ok  = !overflow;
  end

  always_ff @(posedge clk) begin
    if (!flush && push_ok) begin
      if (n_push == 2'd2) begin
        mem[wr_idx0] <= word_lo;
        mem[wr_idx1] <= word_hi;
      end else if (n_push == 2'd1) begin
        mem[wr_idx0] <= word_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(n_push);
      end
      rd_ptr <= rd_ptr + (AW+1)'(n_pop);
      if (overflow) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Data fields are gated by their valid so every output reads 0 while the queue is empty or in reset.
  assign bus.out0_valid = (count != '0);
  assign bus.out1_valid = (count >= (AW+1)'(2));
  assign {bus.out0_pc, bus.out0_inst} = bus.out0_valid ? mem[rd_idx0] : 64'd0;
  assign {bus.out1_pc, bus.out1_inst} = bus.out1_valid ? mem[rd_idx1] : 64'd0;
  assign bus.count_o      = count;
  assign bus.stall_req    = (count >= (AW+1)'(DEPTH - 4));
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue.
// The expected values are hand-computed, and a {pc, inst} queue holds the expected output of the streaming section.
module tb_inst_fetch_queue;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  inst_fetch_queue_if #(.AW(3)) bus ();

  inst_fetch_queue #(.DEPTH(8), .AW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic [31:0] pc_c;
  logic [31:0] pc_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid       = 1'b0;
    bus.req_pc          = 32'd0;
    bus.req_tgt         = 32'd0;
    bus.req_discard     = 1'b0;
    bus.inst_sram_rdata = 64'd0;
  endtask

  // One request cycle followed by its SRAM response cycle
  task automatic send(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic disc, input logic [63:0] data);
    bus.req_valid   = 1'b1;
    bus.req_pc      = pc;
    bus.req_tgt     = tgt;
    bus.req_discard = disc;
    tick();
    idle_inputs();
    bus.inst_sram_rdata = data;
    tick();
    bus.inst_sram_rdata = 64'd0;
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  initial begin
    idle_inputs();
    bus.deq = 2'd0;
    rst     = 1'b0;
    repeat (2) tick();
    check("rst_count", bus.count_o, 0);
    check("rst_out0_valid", bus.out0_valid, 0);
    check("rst_out1_valid", bus.out1_valid, 0);
    check("rst_stall", bus.stall_req, 0);
    check("rst_ovf", bus.overflow_err, 0);
    check("rst_out0_pc", bus.out0_pc, 0);
    rst = 1'b1;
    tick();

    // basic pair
    send(32'hBFC0_0000, 32'hBFC0_0000, 1'b0, 64'h24020001_24010001);
    check("pair_count", bus.count_o, 2);
    check("pair_out0", {bus.out0_valid, bus.out0_pc, bus.out0_inst}, {1'b1, 64'hBFC00000_24010001});
    check("pair_out1", {bus.out1_valid, bus.out1_pc, bus.out1_inst}, {1'b1, 64'hBFC00004_24020001});
    bus.deq = 2'd3;
    tick();
    bus.deq = 2'd0;
    check("deq3_pops_two", bus.count_o, 0);

    // odd target: only the high word is kept
    send(32'hBFC0_0008, 32'hBFC0_000C, 1'b0, 64'h8C420004_8C410000);
    check("odd_count", bus.count_o, 1);
    check("odd_out0_pc", bus.out0_pc, 32'hBFC0_000C);
    check("odd_out0_inst", bus.out0_inst, 32'h8C42_0004);
    check("odd_out1_valid", bus.out1_valid, 0);
    bus.deq = 2'd2;
    tick();
    bus.deq = 2'd0;
    check("deq_clip_count", bus.count_o, 0);

    // discard
    send(32'hBFC0_0010, 32'hBFC0_0010, 1'b1, 64'h11111111_22222222);
    check("discard_count", bus.count_o, 0);

    // flush one cycle after the request kills the in-flight response
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'hBFC0_0018;
    bus.req_tgt   = 32'hBFC0_0018;
    tick();
    idle_inputs();
    flush = 1'b1;
    bus.inst_sram_rdata = 64'h33333333_44444444;
    tick();
    flush = 1'b0;
    idle_inputs();
    check("flush_count", bus.count_o, 0);
    tick();
    check("flush_no_late_push", bus.count_o, 0);

    // a request in the same cycle as flush is not captured
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'hBFC0_0020;
    bus.req_tgt   = 32'hBFC0_0020;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_inputs();
    bus.inst_sram_rdata = 64'h55555555_66666666;
    tick();
    idle_inputs();
    check("flush_same_cycle_req", bus.count_o, 0);

    // streaming with deq=2 every cycle; 20 entries wrap the 8-entry storage
    for (int c = 0; c < 14; c++) begin
      if (c >= 2 && c <= 11) check("stream_count", bus.count_o, 2);
      if (bus.out0_valid) begin
        if (exp_q.size() == 0) check("stream_extra0", 1, 0);
        else begin
          exp_e = exp_q.pop_front();
          check("stream_out0", {bus.out0_pc, bus.out0_inst}, exp_e);
        end
      end
      if (bus.out1_valid) begin
        if (exp_q.size() == 0) check("stream_extra1", 1, 0);
        else begin
          exp_e = exp_q.pop_front();
          check("stream_out1", {bus.out1_pc, bus.out1_inst}, exp_e);
        end
      end
      bus.deq       = 2'd2;
      pc_c          = 32'h0000_1000 + 32'(8 * c);
      pc_p          = pc_c - 32'd8;
      bus.req_valid = (c < 10);
      bus.req_pc    = pc_c;
      bus.req_tgt   = pc_c;
      if (c < 10) begin
        exp_q.push_back({pc_c, mk_inst(pc_c)});
        exp_q.push_back({pc_c + 32'd4, mk_inst(pc_c + 32'd4)});
      end
      bus.inst_sram_rdata = (c >= 1 && c <= 10) ? {mk_inst(pc_p + 32'd4), mk_inst(pc_p)} : 64'd0;
      tick();
    end
    idle_inputs();
    bus.deq = 2'd0;
    check("stream_all_seen", exp_q.size(), 0);
    check("stream_end_count", bus.count_o, 0);

    // back-pressure and overflow with no decode
    send(32'h0000_2000, 32'h0000_2000, 1'b0, 64'hA0000001_A0000000);
    check("bp_count2", bus.count_o, 2);
    check("bp_stall_at2", bus.stall_req, 0);
    send(32'h0000_2008, 32'h0000_2008, 1'b0, 64'hA0000003_A0000002);
    check("bp_count4", bus.count_o, 4);
    check("bp_stall_at4", bus.stall_req, 1);
    send(32'h0000_2010, 32'h0000_2014, 1'b0, 64'hA0000005_A0000004);
    send(32'h0000_2018, 32'h0000_201C, 1'b0, 64'hA0000007_A0000006);
    send(32'h0000_2020, 32'h0000_2024, 1'b0, 64'hA0000009_A0000008);
    check("bp_count7", bus.count_o, 7);
    check("bp_no_ovf_yet", bus.overflow_err, 0);
    send(32'h0000_2028, 32'h0000_2028, 1'b0, 64'hA000000B_A000000A);
    check("ovf_count_kept", bus.count_o, 7);
    check("ovf_flag", bus.overflow_err, 1);
    check("ovf_head_intact", {bus.out0_pc, bus.out0_inst}, 64'h00002000_A0000000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovf_flush_count", bus.count_o, 0);
    check("ovf_sticky", bus.overflow_err, 1);
    check("ovf_flush_out0_valid", bus.out0_valid, 0);

    // async reset in the middle of a cycle
    send(32'h0000_3000, 32'h0000_3000, 1'b0, 64'hB0000001_B0000000);
    send(32'h0000_3008, 32'h0000_3008, 1'b0, 64'hB0000003_B0000002);
    send(32'h0000_3010, 32'h0000_3014, 1'b0, 64'hB0000005_B0000004);
    check("arst_pre_count", bus.count_o, 5);
    check("arst_pre_stall", bus.stall_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", bus.count_o, 0);
    check("arst_out0_valid", bus.out0_valid, 0);
    check("arst_stall", bus.stall_req, 0);
    check("arst_ovf", bus.overflow_err, 0);
    tick();
    rst = 1'b1;
    tick();
    check("arst_post_count", bus.count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
